multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the shared multi-cycle MIPS datapath: single memory port for instructions and data, single ALU, IR, A/B/ALUOut/MDR registers.
- Replaces per-instruction combinational control with a per-state control word.
- Waits on a variable-latency memory handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- OpCode  in  6  IR[31:26], stable from DECODE onward
- Funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if the branch condition (selected by Branch) holds
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- IRWrite  out  1  load IR from memory data
- RegWrite  out  1  register file write
- RegDst  out  2  destination: 00 rt, 01 rd, 10 $31
- MemtoReg  out  2  write data: 00 MDR, 01 ALUOut, 10 PC
- ALUSrcA  out  2  ALU A input: 00 PC, 01 A reg, 10 shamt
- ALUSrcB  out  2  ALU B input: 00 B reg, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  4  {OpCode[0], class}; class: 000 add, 001 sub/compare, 010 R-funct, 100 and, 101 slt
- PCSource  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 A reg
- Branch  out  3  OpCode[2:0] in BRANCH, else 0
- ExtOp  out  1  sign-extend (1) / zero-extend (0)
- LuiOp  out  1  lui immediate shift
- illegal  out  1  1-cycle pulse on an undecodable instruction
- inst_count  out  CNT_W  retired instructions
- state  out  4  current state, for debug

Behaviour:
- Reset
  - reset==0 at posedge: state <= INIT(0), inst_count <= 0.
  - INIT: all control outputs 0. Next cycle FETCH.
  - Reset mid-instruction aborts it; no partial write strobe is asserted after the reset edge.
- Defaults: any output not listed for a state is 0. ExtOp = 1 except for andi.
- FETCH(1)
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=0000, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; then go to DECODE. Otherwise stay.
- DECODE(2)
  - ALUSrcA=00, ALUSrcB=11, ALUOp=0000; precomputes the branch target into ALUOut.
  - Next state: lw/sw -> MEMADDR; R-type jr/jalr -> JUMPR; other R-type -> EXEC_R; addi/addiu/andi/slti/sltiu/lui -> EXEC_I; beq/bne/blez/bgtz/bltz -> BRANCH; j/jal -> JUMP.
  - Any other opcode/funct: illegal=1, go to FETCH, inst_count unchanged.
- MEMADDR(3): ALUSrcA=01, ALUSrcB=10, ALUOp=0000. lw -> MEMRD, sw -> MEMWR.
- MEMRD(4): MemRead=1, IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB(5): RegWrite=1, RegDst=00, MemtoReg=00. Go to FETCH.
- MEMWR(6): MemWrite=1, IorD=1. Hold until mem_ready=1, then go to FETCH.
- EXEC_R(7): ALUOp=0010; ALUSrcB=00; ALUSrcA=10 for sll/srl/sra, else 01. ExtOp=0 for shifts. Go to ALUWB.
- EXEC_I(8): ALUSrcA=01, ALUSrcB=10, ALUOp={OpCode[0],class}; LuiOp=1 for lui. Go to ALUWB.
- ALUWB(9): RegWrite=1, MemtoReg=01; RegDst=01 for R-type, 00 for I-type. Go to FETCH.
- BRANCH(10): ALUSrcA=01, ALUSrcB=00, ALUOp={OpCode[0],001}, Branch=OpCode[2:0], PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP(11): PCWrite=1, PCSource=10. jal also drives RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4). Go to FETCH.
- JUMPR(12): PCWrite=1, PCSource=11. jalr also drives RegWrite=1, RegDst=01, MemtoReg=10. Go to FETCH.
- States 13-15: next state FETCH, outputs 0.
- inst_count increments by 1 on every transition into FETCH from any state except INIT and DECODE (illegal path). Wraps modulo 2^CNT_W.
- Latencies with zero wait (mem_ready=1 on first request):
  - lw 5 cycles; sw, R-type and I-type ALU 4 cycles; branch and jumps 3 cycles.
  - Each memory wait cycle adds 1 cycle.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Test Plan:
- Hold reset=0 for 3 cycles, then release → state=0 for one cycle, then 1 (FETCH); all strobes 0 during INIT; inst_count=0.
- add (OpCode 00, Funct 20), mem_ready tied 1 → states 1,2,7,9,1; RegWrite=1 only in ALUWB with RegDst=01, MemtoReg=01; inst_count=1.
- lw (23) with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total; IRWrite a single pulse; MemtoReg=00 in MEMWB.
- beq (04), then jal (03), then jr (00/08) → BRANCH: PCWriteCond=1, Branch=100; JUMP: RegDst=10, MemtoReg=10, RegWrite=1; JUMPR: PCSource=11, RegWrite=0; inst_count=3.
- Illegal OpCode 3F → illegal pulse in DECODE, return to FETCH, inst_count unchanged.
- reset=0 asserted in the MEMWR wait state → next state INIT; MemWrite=0 from that edge; no count increment.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the shared multi-cycle MIPS datapath: one state per micro-step,
// a decoded control word per state, memory handshake waits and a retired-instruction counter.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [2:0]       Branch,
  output logic             ExtOp,
  output logic             LuiOp,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JUMP, S_JUMPR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BLTZ = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_LUI  = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09;

  state_t cur, nxt;

  function automatic logic legal_funct(input logic [5:0] f);
    case (f)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: legal_funct = 1'b1;
      default:      legal_funct = 1'b0;
    endcase
  endfunction

  logic is_r, is_mem, is_imm, is_br, is_jmp, is_jr, decodable, fixed_shift, any_shift;
  logic [2:0] imm_class;

  assign is_r        = (OpCode == OP_RTYPE) && legal_funct(Funct);
  assign is_jr       = is_r && (Funct == F_JR || Funct == F_JALR);
  assign is_mem      = (OpCode == OP_LW) || (OpCode == OP_SW);
  assign is_imm      = OpCode inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI};
  assign is_br       = OpCode inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ};
  assign is_jmp      = (OpCode == OP_J) || (OpCode == OP_JAL);
  assign decodable   = is_r || is_mem || is_imm || is_br || is_jmp;
  assign fixed_shift = Funct inside {6'h00, 6'h02, 6'h03};
  assign any_shift   = Funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  assign imm_class   = (OpCode == OP_ANDI) ? 3'b100 :
                       (OpCode == OP_SLTI || OpCode == OP_SLTIU) ? 3'b101 : 3'b000;
  assign state       = cur;

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_INIT:    nxt = S_FETCH;
      S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem)      nxt = S_MEMADDR;
        else if (is_jr)  nxt = S_JUMPR;
        else if (is_r)   nxt = S_EXEC_R;
        else if (is_imm) nxt = S_EXEC_I;
        else if (is_br)  nxt = S_BRANCH;
        else if (is_jmp) nxt = S_JUMP;
        else             nxt = S_FETCH;
      end
      S_MEMADDR: nxt = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R, S_EXEC_I: nxt = S_ALUWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // NOTE: every control output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp, illegal} = '0;
    {RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource} = '0;
    ALUOp  = '0;
    Branch = '0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ExtOp   = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = (OpCode != OP_ANDI);
        illegal = !decodable;
      end
      S_MEMADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEMRD:  begin MemRead = 1'b1;  IorD = 1'b1; ExtOp = 1'b1; end
      S_MEMWB:  begin RegWrite = 1'b1; ExtOp = 1'b1; end
      S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; ExtOp = 1'b1; end
      S_EXEC_R: begin
        ALUOp   = 4'b0010;
        ALUSrcA = fixed_shift ? 2'b10 : 2'b01;
        ExtOp   = !any_shift;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = {OpCode[0], imm_class};
        LuiOp   = (OpCode == OP_LUI);
        ExtOp   = (OpCode != OP_ANDI);
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        RegDst   = (OpCode == OP_RTYPE) ? 2'b01 : 2'b00;
        ExtOp    = (OpCode != OP_ANDI);
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = {OpCode[0], 3'b001};
        Branch      = OpCode[2:0];
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        ExtOp       = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        ExtOp    = 1'b1;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      S_JUMPR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        ExtOp    = 1'b1;
        if (Funct == F_JALR) begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          MemtoReg = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur        <= S_INIT;
      inst_count <= '0;
    end else begin
      cur <= nxt;
      // An instruction retires on entry to FETCH, except the post-reset and illegal paths.
      if (nxt == S_FETCH && cur != S_FETCH && cur != S_INIT && cur != S_DECODE)
        inst_count <= inst_count + 1'b1;
    end
  end

endmodule
